// File: rtl/ifetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package ifetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries with synchronous clear.
// Simultaneous push and pop on a full FIFO is accepted.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      push,
    input  fetch_entry_t              wr_data,
    input  logic                      pop,
    output fetch_entry_t              head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == PTR_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr[IDX_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC generation, credit-limited imem requests, prefetch FIFO
// and redirect flush. Define IFETCH_BYPASS_EN for a 0-cycle response-to-decode path.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    fetch_state_e     state;
    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [31:0]      redirect_pc_aligned;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] drop_cnt_nxt;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             unused_fifo_full;
    logic [1:0]       unused_redirect_lsb;
    fetch_entry_t     fifo_head;
    fetch_entry_t     rsp_entry;
    fetch_entry_t     id_entry;
    logic             credit_ok;
    logic             req_fire;
    logic             rsp_fire;
    logic             rsp_keep;
    logic             fifo_push;
    logic             fifo_pop;

    assign redirect_pc_aligned = align_word(redirect_pc);
    assign unused_redirect_lsb = redirect_pc[1:0];

    // Outstanding requests plus buffered words never exceed the FIFO depth.
    assign credit_ok      = (SUM_W'(outstanding) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);
    assign imem_req_valid = (state != IDLE) && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
    assign rsp_fire  = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep  = rsp_fire && (drop_cnt == '0) && !redirect_valid;
    assign rsp_entry = '{pc: rsp_pc, instr: imem_rsp_data};

`ifdef IFETCH_BYPASS_EN
    logic bypass;
    assign bypass    = fifo_empty && rsp_keep;
    assign id_valid  = !fifo_empty || bypass;
    assign id_entry  = fifo_empty ? rsp_entry : fifo_head;
    assign fifo_push = rsp_keep && !(bypass && id_ready);
`else
    assign id_valid  = !fifo_empty;
    assign id_entry  = fifo_head;
    assign fifo_push = rsp_keep;
`endif

    assign fifo_pop = id_valid && id_ready && !redirect_valid && !fifo_empty;
    assign id_instr = id_valid ? id_entry.instr : NOP_INSTR;
    assign id_pc    = id_valid ? id_entry.pc : 32'h0000_0000;

    // Next counter values; a redirect re-arms the drop count from what is still in flight.
    always_comb begin
        outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);
        drop_cnt_nxt    = drop_cnt;
        if (redirect_valid) begin
            drop_cnt_nxt = outstanding_nxt;
        end else if (rsp_fire && (drop_cnt != '0)) begin
            drop_cnt_nxt = drop_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= align_word(RESET_PC);
            rsp_pc      <= align_word(RESET_PC);
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;

            case (state)
                IDLE:        state <= RUN;
                RUN, FLUSH:  state <= (drop_cnt_nxt != '0) ? FLUSH : RUN;
                default:     state <= IDLE;
            endcase

            if (redirect_valid) begin
                fetch_pc <= redirect_pc_aligned;
                rsp_pc   <= redirect_pc_aligned;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_keep) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (redirect_valid),
        .push    (fifo_push),
        .wr_data (rsp_entry),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (unused_fifo_full)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-cycle vector table plus directed
// sequences for flush, double redirect, alignment/wrap, stall and reset.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    instr_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] redir_pc;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_id_valid;
        logic [31:0] exp_id_pc;
    } vec_t;

    mreq_t mq[$];
    ent_t  got[$];
    vec_t  tbl [16];
    int    cyc = 0;
    int    lat = 1;
    int    req_count = 0;
    int    checks = 0;
    int    failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // In-order memory: a request accepted at the edge ending cycle n answers in cycle n+lat.
    task automatic mem_drive();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic step();
        #1;
        if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{imem_req_addr, cyc + lat});
            req_count++;
        end
        if (id_valid && id_ready && !redirect_valid) begin
            got.push_back('{id_pc, id_instr});
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        mem_drive();
    endtask

    task automatic redirect_step(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset(input int l);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        mq.delete();
        got.delete();
        lat = l;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        cyc       = 0;
        req_count = 0;
        mem_drive();
    endtask

    task automatic wait_got(input int n, input string name);
        int budget;
        budget = 60;
        while (got.size() < n && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        if (got.size() < n) begin
            failures++;
            $display("FAIL %s_timeout: got %0d entries expected %0d", name, got.size(), n);
        end
    endtask

    task automatic chk_got(input int i, input logic [31:0] pc, input string name);
        if (i < got.size()) begin
            chk({name, "_pc"}, got[i].pc, pc);
            chk({name, "_instr"}, got[i].instr, mem_word(pc));
        end
    endtask

    initial begin
        do_reset(1);

`ifndef IFETCH_BYPASS_EN
        // rdy, redir, redir_pc, exp_req_valid, exp_req_addr, exp_id_valid, exp_id_pc
        tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h108, 1'b1, 32'h100};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h10C, 1'b1, 32'h104};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h10C, 1'b1, 32'h104};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h10C, 1'b1, 32'h104};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h10C, 1'b1, 32'h104};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h10C, 1'b1, 32'h104};
        tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h108};
        tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h110, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h114, 1'b1, 32'h10C};
        tbl[13] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0};
        tbl[15] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h208, 1'b1, 32'h200};

        for (int i = 0; i < 16; i++) begin
            id_ready       = tbl[i].rdy;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].redir_pc;
            #1;
            chk($sformatf("c%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].exp_req_valid));
            chk($sformatf("c%0d_req_addr", i), imem_req_addr, tbl[i].exp_req_addr);
            chk($sformatf("c%0d_id_valid", i), 32'(id_valid), 32'(tbl[i].exp_id_valid));
            chk($sformatf("c%0d_id_pc", i), id_pc, tbl[i].exp_id_pc);
            chk($sformatf("c%0d_id_instr", i), id_instr,
                tbl[i].exp_id_valid ? mem_word(tbl[i].exp_id_pc) : NOP);
            step();
        end
        redirect_valid = 1'b0;
`else
        // Empty FIFO: the first kept response is visible to decode in its own cycle.
        step();
        step();
        #1;
        chk("byp_id_valid", 32'(id_valid), 32'd1);
        chk("byp_id_pc", id_pc, RST_PC);
        chk("byp_id_instr", id_instr, mem_word(RST_PC));
        wait_got(3, "byp");
        chk_got(0, 32'h100, "byp0");
        chk_got(1, 32'h104, "byp1");
        chk_got(2, 32'h108, "byp2");
`endif

        // Latency 3, two in flight, redirect: both stale words dropped.
        do_reset(3);
        repeat (3) step();
        #1 chk("a_credit_cap", 32'(imem_req_valid), 32'd0);
        redirect_step(32'h200);
        #1 chk("a_stale_cap", 32'(imem_req_valid), 32'd0);
        wait_got(2, "a");
        chk_got(0, 32'h200, "a0");
        chk_got(1, 32'h204, "a1");

        // Redirect coincident with a response, then a second redirect next cycle.
        do_reset(3);
        repeat (4) step();
        redirect_step(32'h200);
        redirect_step(32'h300);
        #1;
        chk("b_req_valid", 32'(imem_req_valid), 32'd1);
        chk("b_req_addr", imem_req_addr, 32'h300);
        wait_got(3, "b");
        chk_got(0, 32'h300, "b0");
        chk_got(1, 32'h304, "b1");
        chk_got(2, 32'h308, "b2");

        // Unaligned redirect target and 32-bit PC wrap.
        do_reset(1);
        step();
        redirect_step(32'h0000_0007);
        #1;
        chk("c_align_valid", 32'(imem_req_valid), 32'd1);
        chk("c_align_addr", imem_req_addr, 32'h0000_0004);
        step();
        redirect_step(32'hFFFF_FFFC);
        #1;
        chk("c_top_valid", 32'(imem_req_valid), 32'd1);
        chk("c_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        step();
        #1;
        chk("c_wrap_valid", 32'(imem_req_valid), 32'd1);
        chk("c_wrap_addr", imem_req_addr, 32'h0000_0000);
        wait_got(3, "c");
        chk_got(0, 32'hFFFF_FFFC, "c0");
        chk_got(1, 32'h0000_0000, "c1");
        chk_got(2, 32'h0000_0004, "c2");

        // Decode stalled well past the credit limit, then drained in order.
        do_reset(1);
        id_ready = 1'b0;
        repeat (12) step();
        #1;
        chk("e_req_count", 32'(req_count), 32'(DEPTH));
        chk("e_none_consumed", 32'(got.size()), 32'd0);
        chk("e_held_pc", id_pc, RST_PC);
        id_ready = 1'b1;
        wait_got(4, "e");
        chk_got(0, 32'h100, "e0");
        chk_got(1, 32'h104, "e1");
        chk_got(2, 32'h108, "e2");
        chk_got(3, 32'h10C, "e3");

        // Reset while flushing; late responses must not reach decode.
        do_reset(4);
        repeat (3) step();
        redirect_step(32'h200);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        got.delete();
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("d_quiet%0d", i), 32'(id_valid), 32'd0);
            step();
        end
        wait_got(1, "d");
        chk_got(0, RST_PC, "d0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
